// File: rtl/dds_rom_reader.sv
// dds_rom_reader: phase-accumulator reader for a 1-cycle synchronous waveform ROM.
// Issues ROM addresses with credit-based flow control, absorbs the read latency
// and delivers samples (with a period-start tag) through a small FIFO onto a
// valid/ready stream.
module dds_rom_reader #(
    parameter int PHASE_W    = 32,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [ADDR_W-1:0]  phase_off,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_wrap,
    output logic               sample_valid,
    input  logic               sample_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

    // Phase accumulator and read pipeline
    logic [PHASE_W-1:0] acc_reg;
    logic               carry_pend_reg;   // last accumulator add carried out
    logic               p1_reg;           // read issued, ROM sampling address now
    logic               p2_reg;           // ROM data valid on rom_data now
    logic               wrap1_reg;
    logic               wrap2_reg;
    logic [ADDR_W-1:0]  rom_addr_reg;

    // FIFO state
    logic [DATA_W:0]    entry_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [PHASE_W:0]   acc_sum;
    logic [CNT_W:0]     in_use;
    logic               fetch;
    logic               push;
    logic               pop;
    logic [DATA_W:0]    head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy plus in-flight reads forms the credit check, so the FIFO cannot overflow
    assign acc_sum = {1'b0, acc_reg} + {1'b0, freq_word};
    assign in_use  = {1'b0, count_reg} + (CNT_W + 1)'(p1_reg) + (CNT_W + 1)'(p2_reg);
    assign fetch   = en & ~sync_clr & (in_use < DEPTH_L);
    assign push    = p2_reg & ~sync_clr;
    assign pop     = sample_valid & sample_ready & ~sync_clr;

    assign rom_addr     = rom_addr_reg;
    assign sample_valid = (count_reg != '0);
    assign head         = entry_reg[rd_ptr_reg];
    assign sample       = sample_valid ? head[DATA_W-1:0] : '0;
    assign sample_wrap  = sample_valid ? head[DATA_W] : 1'b0;

    // Accumulator, address issue and read-latency pipeline; the wrap tag marks
    // the first read issued after an accumulator carry-out
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            acc_reg        <= '0;
            carry_pend_reg <= 1'b0;
            rom_addr_reg   <= '0;
            p1_reg         <= 1'b0;
            p2_reg         <= 1'b0;
            wrap1_reg      <= 1'b0;
            wrap2_reg      <= 1'b0;
        end else if (sync_clr) begin
            acc_reg        <= '0;
            carry_pend_reg <= 1'b0;
            p1_reg         <= 1'b0;
            p2_reg         <= 1'b0;
            wrap1_reg      <= 1'b0;
            wrap2_reg      <= 1'b0;
        end else begin
            p2_reg    <= p1_reg;
            wrap2_reg <= wrap1_reg;
            if (fetch) begin
                rom_addr_reg   <= acc_reg[PHASE_W-1 -: ADDR_W] + phase_off;
                acc_reg        <= acc_sum[PHASE_W-1:0];
                carry_pend_reg <= acc_sum[PHASE_W];
                p1_reg         <= 1'b1;
                wrap1_reg      <= carry_pend_reg;
            end else begin
                p1_reg    <= 1'b0;
            end
        end
    end

    // FIFO pointer and occupancy update; a clear empties the queue and ignores any pop
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (sync_clr) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // FIFO storage, one {wrap, data} register per entry
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            // Capture the returning ROM word into this slot when it is the write target
            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    entry_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= {wrap2_reg, rom_data};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dds_rom_reader.sv
// Testbench for dds_rom_reader: ROM model returns data = address one cycle late.
// Directed table of known sample values, hand sequences for backpressure, clear
// and reset, and randomized en/ready traffic checked against an arithmetic model.
module tb_dds_rom_reader;

    logic        clka = 1'b0;
    logic        rsta;
    logic        en;
    logic        sync_clr;
    logic [31:0] freq_word;
    logic [9:0]  phase_off;
    logic [9:0]  rom_addr;
    logic [9:0]  rom_data = '0;
    logic [9:0]  sample;
    logic        sample_wrap;
    logic        sample_valid;
    logic        sample_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_start  = 0;

    int got_s[$];
    int got_w[$];
    int got_t[$];

    typedef struct {
        logic [31:0] freq;
        logic [9:0]  off;
        int          k;
        int          s;
        int          w;
    } vec_t;

    vec_t tbl[14];

    dds_rom_reader dut (
        .clka         (clka),
        .rsta         (rsta),
        .en           (en),
        .sync_clr     (sync_clr),
        .freq_word    (freq_word),
        .phase_off    (phase_off),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_wrap  (sample_wrap),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    always #5 clka = ~clka;

    // Single-port ROM with 1-cycle synchronous read, contents = address
    always @(posedge clka) rom_data <= rom_addr;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    endtask

    // Reference: sample k is the top address bits of k*freq plus offset; the tag
    // is set when the integer part of the phase advanced between k-1 and k
    function automatic int m_addr(input int k, input logic [31:0] f, input logic [9:0] o);
        logic [63:0] p;
        logic [9:0]  a;
        p = 64'(k) * 64'(f);
        a = p[31:22] + o;
        return int'(a);
    endfunction

    function automatic int m_wrap(input int k, input logic [31:0] f);
        logic [63:0] p;
        logic [63:0] q;
        if (k == 0) return 0;
        p = 64'(k) * 64'(f);
        q = 64'(k - 1) * 64'(f);
        return (p[63:32] != q[63:32]) ? 1 : 0;
    endfunction

    task automatic collect(input int n, input int rdy_pct, input int en_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clka);
            cyc++;
            sample_ready = ($urandom_range(99) < rdy_pct);
            en           = ($urandom_range(99) < en_pct);
            if (sample_valid && sample_ready) begin
                got_s.push_back(int'(sample));
                got_w.push_back(int'(sample_wrap));
                got_t.push_back(cyc);
            end
        end
        @(posedge clka);
        #1;
    endtask

    task automatic restart(input logic [31:0] f, input logic [9:0] o);
        @(negedge clka);
        cyc++;
        freq_word    = f;
        phase_off    = o;
        sync_clr     = 1'b1;
        en           = 1'b1;
        sample_ready = 1'b1;
        @(negedge clka);
        cyc++;
        chk("clr_valid", int'(sample_valid), 0);
        chk("clr_sample", int'(sample), 0);
        sync_clr = 1'b0;
        got_s.delete();
        got_w.delete();
        got_t.delete();
        t_start = cyc;
    endtask

    task automatic check_stream(input string nm, input logic [31:0] f, input logic [9:0] o);
        for (int k = 0; k < got_s.size(); k++) begin
            chk({nm, "_sample"}, got_s[k], m_addr(k, f, o));
            chk({nm, "_wrap"}, got_w[k], m_wrap(k, f));
        end
    endtask

    initial begin
        logic [9:0]  a0;
        logic [9:0]  h0;
        int          nb;
        logic [31:0] rf;
        logic [9:0]  ro;

        tbl[0]  = '{32'h0040_0000, 10'd0,    0,    0, 0};
        tbl[1]  = '{32'h0040_0000, 10'd0,    1,    1, 0};
        tbl[2]  = '{32'h0040_0000, 10'd0,  512,  512, 0};
        tbl[3]  = '{32'h0040_0000, 10'd0, 1023, 1023, 0};
        tbl[4]  = '{32'h0040_0000, 10'd0, 1024,    0, 1};
        tbl[5]  = '{32'h0040_0000, 10'd0, 1025,    1, 0};
        tbl[6]  = '{32'h8000_0000, 10'd3,    0,    3, 0};
        tbl[7]  = '{32'h8000_0000, 10'd3,    1,  515, 0};
        tbl[8]  = '{32'h8000_0000, 10'd3,    2,    3, 1};
        tbl[9]  = '{32'h8000_0000, 10'd3,    3,  515, 0};
        tbl[10] = '{32'h8000_0000, 10'd3,    4,    3, 1};
        tbl[11] = '{32'h0040_0000, 10'd1023, 0, 1023, 0};
        tbl[12] = '{32'h0040_0000, 10'd1023, 1,    0, 0};
        tbl[13] = '{32'h0040_0000, 10'd1023, 2,    1, 0};

        // Reset state
        rsta = 1'b1; en = 1'b0; sync_clr = 1'b0; sample_ready = 1'b0;
        freq_word = '0; phase_off = '0;
        repeat (3) @(negedge clka);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_wrap", int'(sample_wrap), 0);
        chk("rst_valid", int'(sample_valid), 0);
        rsta = 1'b0;

        // Directed table: known sample values, fill latency and full throughput
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || tbl[i].freq != tbl[i-1].freq || tbl[i].off != tbl[i-1].off) begin
                restart(tbl[i].freq, tbl[i].off);
                collect(1040, 100, 100);
                if (got_s.size() > 1) begin
                    chk("fill_latency", got_t[0] - t_start, 3);
                    chk("throughput", got_t[got_s.size()-1] - got_t[0], got_s.size() - 1);
                end else begin
                    chk("stream_started", got_s.size(), 1040 - 2);
                end
            end
            if (tbl[i].k < got_s.size()) begin
                chk($sformatf("tbl%0d_sample", i), got_s[tbl[i].k], tbl[i].s);
                chk($sformatf("tbl%0d_wrap", i), got_w[tbl[i].k], tbl[i].w);
            end else begin
                chk($sformatf("tbl%0d_present", i), got_s.size(), tbl[i].k + 1);
            end
        end

        // Backpressure: stall, four queued, drain with en=0, then resume in order
        restart(32'h0040_0000, 10'd0);
        collect(25, 100, 100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clka);
            cyc++;
            sample_ready = 1'b0;
            if (i == 0) h0 = sample;
            if (i == 2) a0 = rom_addr;
        end
        chk("stall_rom_addr", int'(rom_addr), int'(a0));
        chk("stall_head", int'(sample), int'(h0));
        chk("stall_valid", int'(sample_valid), 1);
        nb = got_s.size();
        collect(8, 100, 0);
        chk("stall_queued", got_s.size() - nb, 4);
        collect(20, 100, 100);
        check_stream("stall", 32'h0040_0000, 10'd0);

        // Mid-stream clear restarts the phase at the offset
        restart(32'h0123_4567, 10'd5);
        collect(12, 100, 100);
        restart(32'h0040_0000, 10'd5);
        collect(10, 100, 100);
        check_stream("clr", 32'h0040_0000, 10'd5);

        // Asynchronous reset with reads in flight
        restart(32'h0040_0000, 10'd7);
        collect(10, 100, 100);
        #2;
        rsta = 1'b1;
        #1;
        chk("arst_valid", int'(sample_valid), 0);
        chk("arst_sample", int'(sample), 0);
        chk("arst_wrap", int'(sample_wrap), 0);
        chk("arst_rom_addr", int'(rom_addr), 0);
        @(negedge clka);
        cyc++;
        rsta = 1'b0;
        got_s.delete(); got_w.delete(); got_t.delete();
        t_start = cyc;
        collect(10, 100, 100);
        chk("arst_count", got_s.size(), 8);
        check_stream("arst", 32'h0040_0000, 10'd7);

        // Randomized en/ready traffic against the arithmetic model
        for (int seg = 0; seg < 8; seg++) begin
            case (seg)
                0:       rf = 32'h0;
                1:       rf = 32'hFFFF_FFFF;
                2:       rf = 32'($urandom_range(1, 4096));
                default: rf = $urandom;
            endcase
            ro = 10'($urandom_range(0, 1023));
            restart(rf, ro);
            collect(300, 60, 80);
            chk("rand_progress", (got_s.size() > 20) ? 1 : 0, 1);
            check_stream($sformatf("rand%0d", seg), rf, ro);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
